// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory loader: FSM state encoding,
// stream framing sizes and the helper that decodes the "session active" states.
package loader_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LEN_LO = 3'd1;
  localparam logic [2:0] ST_LEN_HI = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;
  localparam logic [2:0] ST_ERR    = 3'd5;

  localparam int LEN_BYTES      = 2;
  localparam int LEN_W          = LEN_BYTES * 8;
  localparam int BYTES_PER_WORD = 4;
  localparam int LANE_W         = $clog2(BYTES_PER_WORD);

  // The loader consumes bytes exactly while a session is in progress.
  function automatic logic state_busy(input logic [2:0] st);
    return (st == ST_LEN_LO) || (st == ST_LEN_HI) || (st == ST_DATA);
  endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs accepted bytes little-endian into a 32-bit word and flags the byte
// that completes it; next_word already includes that completing byte.
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [31:0] next_word,
  output logic        word_done
);

  logic [LANE_W-1:0]                 byte_cnt;
  logic [BYTES_PER_WORD-1:0][7:0]    lanes;
  logic [BYTES_PER_WORD-1:0][7:0]    merged;

  always_comb begin
    merged           = lanes;
    merged[byte_cnt] = byte_in;
  end

  assign next_word = merged;
  assign word_done = byte_valid && (byte_cnt == LANE_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      lanes    <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
      lanes    <= '0;
    end else if (byte_valid) begin
      byte_cnt <= byte_cnt + 1'b1;
      lanes    <= merged;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length-prefixed byte stream, writes words into the
// instruction memory and keeps the core in reset until a full image is in.
module imem_loader
  import loader_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_hold,
  output logic [15:0]       words_loaded
);

  logic [2:0]       state;
  logic [7:0]       len_lo;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] len_n;
  logic             accept;
  logic             start_go;
  logic             data_byte;
  logic             word_done;
  logic [31:0]      next_word;

  assign rx_ready = state_busy(state);
  assign busy     = state_busy(state);
  assign done     = (state == ST_DONE);
  assign error    = (state == ST_ERR);
  assign cpu_hold = (state != ST_DONE);

  // start is only honoured outside a session, where rx_ready is low, so a
  // start and a byte accept can never land on the same edge.
  assign accept    = rx_valid && rx_ready;
  assign start_go  = start && !rx_ready;
  assign data_byte = accept && (state == ST_DATA);
  assign len_n     = {rx_data, len_lo};

  word_assembler u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (start_go),
    .byte_valid (data_byte),
    .byte_in    (rx_data),
    .next_word  (next_word),
    .word_done  (word_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      len_lo       <= '0;
      len          <= '0;
      mem_we       <= 1'b0;
      mem_waddr    <= '0;
      mem_wdata    <= '0;
      words_loaded <= '0;
    end else begin
      mem_we <= 1'b0;
      if (start_go) begin
        state        <= ST_LEN_LO;
        len_lo       <= '0;
        len          <= '0;
        words_loaded <= '0;
      end else if (accept) begin
        case (state)
          ST_LEN_LO: begin
            len_lo <= rx_data;
            state  <= ST_LEN_HI;
          end
          ST_LEN_HI: begin
            len <= len_n;
            if (len_n == '0)
              state <= ST_DONE;
            else if (len_n > LEN_W'(DEPTH))
              state <= ST_ERR;
            else
              state <= ST_DATA;
          end
          ST_DATA: begin
            // words_loaded doubles as the word index; it never exceeds DEPTH.
            if (word_done) begin
              mem_we       <= 1'b1;
              mem_waddr    <= words_loaded[ADDR_W-1:0];
              mem_wdata    <= next_word;
              words_loaded <= words_loaded + 16'd1;
              if (words_loaded == len - 16'd1)
                state <= ST_DONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: the driver queues expected writes from a
// byte-level model of the stream, a negedge monitor pops them on every mem_we.
module tb_imem_loader;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic              busy;
  logic              done;
  logic              error;
  logic              cpu_hold;
  logic [15:0]       words_loaded;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .mem_we       (mem_we),
    .mem_waddr    (mem_waddr),
    .mem_wdata    (mem_wdata),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .cpu_hold     (cpu_hold),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic [31:0] data;
    bit          last;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] payload[$];
  wr_t        mon_e;
  int         checks = 0;
  int         errors = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Every write the DUT makes must be the next one the model predicted.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_write: got waddr %0d wdata 0x%08h, expected no write",
                 mem_waddr, mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        check_output("waddr", 32'(mem_waddr), 32'(mon_e.addr));
        check_output("wdata", mem_wdata, mon_e.data);
        check_output("words_loaded_at_write", 32'(words_loaded), 32'(mon_e.addr + 1));
        check_output("done_at_write", 32'(done), 32'(mon_e.last));
        check_output("cpu_hold_at_write", 32'(cpu_hold), 32'(!mon_e.last));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    rx_valid = 1'b0;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  // Offers one byte and returns just after the edge that accepts it.
  task automatic send_byte(input logic [7:0] b, input bit gaps, input bit strict, input bit poke_start);
    int wait_cnt;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        start    = poke_start && ($urandom_range(0, 2) == 0);
        tick();
        start    = 1'b0;
      end
    end
    rx_valid = 1'b1;
    rx_data  = b;
    if (strict)
      check_output("no_stall", 32'(rx_ready), 32'd1);
    wait_cnt = 0;
    while (rx_ready !== 1'b1 && wait_cnt < 50) begin
      tick();
      wait_cnt++;
    end
    if (rx_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got rx_ready %b, expected 1 within 50 cycles", rx_ready);
    end
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic apply_stimulus(input int n, input bit gaps, input bit strict);
    logic [15:0] nn;
    logic [7:0]  b[4];
    logic [31:0] w;
    nn = 16'(n);
    pulse_start();
    check_output("ready_after_start", 32'(rx_ready), 32'd1);
    check_output("error_cleared", 32'(error), 32'd0);
    check_output("done_cleared", 32'(done), 32'd0);
    check_output("words_cleared", 32'(words_loaded), 32'd0);
    send_byte(nn[7:0], 1'b0, strict, 1'b0);
    send_byte(nn[15:8], 1'b0, strict, 1'b0);
    if (n == 0) begin
      check_output("len0_done", 32'(done), 32'd1);
      check_output("len0_cpu_hold", 32'(cpu_hold), 32'd0);
    end else if (n > DEPTH) begin
      check_output("err_flag", 32'(error), 32'd1);
      check_output("err_rx_ready", 32'(rx_ready), 32'd0);
      check_output("err_cpu_hold", 32'(cpu_hold), 32'd1);
    end else begin
      for (int wi = 0; wi < n; wi++) begin
        w = '0;
        for (int k = 0; k < 4; k++) begin
          b[k] = (payload.size() != 0) ? payload.pop_front() : 8'($urandom);
          w    = w + (32'(b[k]) << (8 * k));
        end
        exp_q.push_back('{addr: wi, data: w, last: (wi == n - 1)});
        for (int k = 0; k < 4; k++)
          send_byte(b[k], gaps, strict, gaps);
      end
    end
    repeat (3) tick();
    check_output("queue_drained", 32'(exp_q.size()), 32'd0);
    check_output("end_busy", 32'(busy), 32'd0);
    check_output("end_done", 32'(done), 32'(n <= DEPTH));
    check_output("end_error", 32'(error), 32'(n > DEPTH));
    check_output("end_cpu_hold", 32'(cpu_hold), 32'(n > DEPTH));
    check_output("end_words", 32'(words_loaded), (n <= DEPTH) ? 32'(n) : 32'd0);
  endtask

  // Valid bytes offered outside a session must be refused and never written.
  task automatic idle_garbage();
    repeat (3) begin
      rx_valid = 1'b1;
      rx_data  = 8'($urandom);
      check_output("idle_not_ready", 32'(rx_ready), 32'd0);
      tick();
    end
    rx_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    check_output({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check_output({tag, "_waddr"}, 32'(mem_waddr), 32'd0);
    check_output({tag, "_wdata"}, mem_wdata, 32'd0);
    check_output({tag, "_busy"}, 32'(busy), 32'd0);
    check_output({tag, "_done"}, 32'(done), 32'd0);
    check_output({tag, "_error"}, 32'(error), 32'd0);
    check_output({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    check_output({tag, "_words"}, 32'(words_loaded), 32'd0);
  endtask

  initial begin
    logic [7:0] demo[8];
    rst_n    = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) tick();
    check_reset_values("reset");
    rst_n = 1'b1;
    tick();
    idle_garbage();

    demo = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    foreach (demo[i]) payload.push_back(demo[i]);
    apply_stimulus(2, 1'b0, 1'b0);
    idle_garbage();

    apply_stimulus(0, 1'b0, 1'b0);
    apply_stimulus(65, 1'b0, 1'b0);
    idle_garbage();
    apply_stimulus(0, 1'b0, 1'b0);

    apply_stimulus(DEPTH, 1'b0, 1'b1);

    for (int s = 0; s < 6; s++)
      apply_stimulus($urandom_range(1, 10), 1'b1, 1'b0);

    // Abort a session after five data bytes: one word written, one dropped.
    pulse_start();
    send_byte(8'h02, 1'b0, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0, 1'b0);
    exp_q.push_back('{addr: 0, data: 32'h44332211, last: 1'b0});
    send_byte(8'h11, 1'b0, 1'b0, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0, 1'b0);
    send_byte(8'h33, 1'b0, 1'b0, 1'b0);
    send_byte(8'h44, 1'b0, 1'b0, 1'b0);
    send_byte(8'h55, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    check_output("midreset_queue", 32'(exp_q.size()), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    apply_stimulus(3, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
